// File: rtl/test_area_prmter_deadlock_pkg.sv
// test_area_prmter_deadlock_pkg: shared FSM states, report sizing and field offsets for the deadlock reporter
// Report width grows by TS_W when DEADLOCK_TIMESTAMP_EN is defined.
package test_area_prmter_deadlock_pkg;
  typedef enum logic [1:0] {ARMED, COUNT, REPORT, WAIT_CLR} state_t;
  localparam int TS_W = 32;
  localparam int IDLE_OFS = 0;
  function automatic int report_w(input int thresh_w, input int num_proc);
`ifdef DEADLOCK_TIMESTAMP_EN
    return TS_W + thresh_w + 3 * num_proc;
`else
    return thresh_w + 3 * num_proc;
`endif
  endfunction
  function automatic int chan_ofs(input int num_proc);
    return num_proc;
  endfunction
  function automatic int axis_ofs(input int num_proc);
    return 2 * num_proc;
  endfunction
  function automatic int stall_ofs(input int num_proc);
    return 3 * num_proc;
  endfunction
  function automatic int ts_ofs(input int thresh_w, input int num_proc);
    return thresh_w + 3 * num_proc;
  endfunction
endpackage

// File: rtl/test_area_prmter_stall_counter.sv
// test_area_prmter_stall_counter: saturating counter with clear/increment and a reach-threshold-on-next-increment flag
// Ports: clock, reset (async active-low), clr, inc, thr -> count_next (saturated count+1), hit (count+1 >= thr).
// clr together with inc loads 1, so a run can restart in the same cycle it is cleared.
module test_area_prmter_stall_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] thr,
  output logic [W-1:0] count_next,
  output logic         hit
);
  logic [W-1:0] count;
  assign count_next = &count ? count : count + W'(1);
  assign hit = ({1'b0, count} + (W+1)'(1)) >= {1'b0, thr};
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= W'(inc);
    else if (inc) count <= count_next;
endmodule

// File: rtl/test_area_prmter_deadlock_reporter.sv
// test_area_prmter_deadlock_reporter: qualifies raw deadlock block, reports one snapshot word per event and raises a sticky irq
// Ports: clock, reset (async active-low), enable, block, proc_idle/proc_chan_block/proc_axis_block, cfg_threshold,
//   irq_clear, report_valid/report_ready/report_data, deadlock_irq, event_count.
// Optional: DEADLOCK_TIMESTAMP_EN prepends a 32-bit free-running cycle stamp to report_data.
module test_area_prmter_deadlock_reporter
  import test_area_prmter_deadlock_pkg::*;
#(
  parameter int NUM_PROC = 5,
  parameter int THRESH_W = 16,
  parameter int EVT_W = 8,
  localparam int REPORT_W = report_w(THRESH_W, NUM_PROC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                block,
  input  logic [NUM_PROC-1:0] proc_idle,
  input  logic [NUM_PROC-1:0] proc_chan_block,
  input  logic [NUM_PROC-1:0] proc_axis_block,
  input  logic [THRESH_W-1:0] cfg_threshold,
  input  logic                irq_clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [REPORT_W-1:0] report_data,
  output logic                deadlock_irq,
  output logic [EVT_W-1:0]    event_count
);
  state_t state;
  logic [THRESH_W-1:0] thr_q, stall_next;
  logic [REPORT_W-1:0] snap;
  logic go, hit, rearm_q;
  assign go = enable & block;
  test_area_prmter_stall_counter #(.W(THRESH_W)) u_stall (
    .clock(clock),
    .reset(reset),
    .clr(state != COUNT || !go),
    .inc(go && (state == ARMED || state == COUNT)),
    .thr(thr_q),
    .count_next(stall_next),
    .hit(hit)
  );
`ifdef DEADLOCK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) ts_q <= '0;
    else ts_q <= ts_q + TS_W'(1);
  assign snap = {ts_q, stall_next, proc_axis_block, proc_chan_block, proc_idle};
`else
  assign snap = {stall_next, proc_axis_block, proc_chan_block, proc_idle};
`endif
  // In ARMED the counter is 0, so hit there means thr_q == 1 and the first blocked cycle confirms.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ARMED;
      thr_q <= THRESH_W'(1);
      report_valid <= 1'b0;
      report_data <= '0;
      deadlock_irq <= 1'b0;
      event_count <= '0;
      rearm_q <= 1'b0;
    end else begin
      if (irq_clear) deadlock_irq <= 1'b0;
      case (state)
        ARMED: begin
          thr_q <= cfg_threshold == '0 ? THRESH_W'(1) : cfg_threshold;
          if (go && hit) begin
            report_data <= snap;
            report_valid <= 1'b1;
            state <= REPORT;
          end else if (go) state <= COUNT;
        end
        COUNT:
          if (!go) state <= ARMED;
          else if (hit) begin
            report_data <= snap;
            report_valid <= 1'b1;
            state <= REPORT;
          end
        REPORT:
          if (report_ready) begin
            report_valid <= 1'b0;
            deadlock_irq <= 1'b1;
            event_count <= &event_count ? event_count : event_count + EVT_W'(1);
            state <= WAIT_CLR;
          end
        WAIT_CLR: begin
          if (irq_clear) rearm_q <= 1'b1;
          if ((rearm_q || irq_clear) && !block) begin
            rearm_q <= 1'b0;
            state <= ARMED;
          end
        end
      endcase
    end
endmodule

// File: doc/test_area_prmter_deadlock_reporter.md
# test_area_prmter_deadlock_reporter

Controller that qualifies the raw `block` indication of the Test_area_prmter dataflow deadlock monitor and turns it into a confirmed, reportable event. It counts consecutive blocked cycles against a programmable threshold and snapshots the per-process stop vectors. It then delivers one report word over a valid/ready handshake, raises a sticky interrupt and re-arms only under software control. It sits beside the idx0 monitor inside the HLS IP wrapper and drives the debug/interrupt path.

## Interface
- `NUM_PROC`, 5: number of dataflow processes covered by the vectors.
- `THRESH_W`, 16: width of the threshold and of the stall counter.
- `EVT_W`, 8: width of the saturating event counter.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arms detection; when low, the block does not count.
- `block`  in  1  raw deadlock indication from the idx0 monitor.
- `proc_idle`  in  NUM_PROC  per-process idle vector.
- `proc_chan_block`  in  NUM_PROC  per-process channel-blocked vector.
- `proc_axis_block`  in  NUM_PROC  per-process AXIS-blocked vector.
- `cfg_threshold`  in  THRESH_W  number of consecutive blocked cycles needed to confirm.
- `irq_clear`  in  1  single-cycle pulse; acknowledges the interrupt and requests re-arm.
- `report_valid`  out  1  report word available.
- `report_ready`  in  1  consumer accepts the report word.
- `report_data`  out  REPORT_W  `{stall_count, proc_axis_block, proc_chan_block, proc_idle}`, with the timestamp prepended when enabled.
- `deadlock_irq`  out  1  sticky confirmed-deadlock flag.
- `event_count`  out  EVT_W  number of confirmed deadlocks, saturating.

## Operation
- FSM states: ARMED, COUNT, REPORT, WAIT_CLR.
- ARMED:
  - stall_count = 0.
  - `cfg_threshold` is captured into thr_q every cycle in this state only; a value of 0 is captured as 1.
  - If `enable && block`: stall_count <= 1 and the FSM goes to COUNT.
  - If thr_q = 1 in that same cycle, the FSM goes straight to REPORT.
- COUNT:
  - While `block` is high, stall_count increments, saturating at all-ones.
  - When `block` is high and stall_count+1 >= thr_q: snapshot the vectors and stall_count+1 into report_q, then go to REPORT.
  - `block` low or `enable` low: clear stall_count and return to ARMED.
- REPORT:
  - `report_valid` = 1 and `report_data` = report_q, both held stable until `report_ready`.
  - `enable` and `block` are ignored, so valid is never withdrawn.
  - On the handshake cycle: `deadlock_irq` <= 1, event_count increments (saturating), and the FSM goes to WAIT_CLR.
- WAIT_CLR:
  - `irq_clear` clears `deadlock_irq` and sets rearm_q.
  - The FSM goes to ARMED on the first cycle with rearm_q (or `irq_clear`) && !`block`.
  - A persisting deadlock is therefore reported only once.
- `irq_clear` in any other state clears `deadlock_irq` only.
- Reset mid-operation returns everything to reset values; any pending report is discarded.

## Timing
- Reset values: `report_valid` 0, `report_data` 0, `deadlock_irq` 0, `event_count` 0, FSM in ARMED, thr_q 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: `report_valid` rises on the edge after the cycle in which the thr_q-th consecutive `block` is sampled.
  - With thr_q = N, first `block` sampled at cycle 0 gives `report_valid` high in cycle N.
- `deadlock_irq` rises in the cycle after the handshake.
- `report_valid` with `report_ready` tied high lasts exactly 1 cycle.
- `irq_clear` in the same cycle as the handshake: the handshake wins, `deadlock_irq` is set, and the clear is lost.
- event_count at max stays at max; stall_count saturation never wraps to 0.

## Configuration
- `DEADLOCK_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter runs from reset and wraps at 2^32.
  - Its value at the snapshot cycle is prepended to `report_data`.
  - REPORT_W = 32 + THRESH_W + 3*NUM_PROC.
- Undefined: no counter is built and REPORT_W = THRESH_W + 3*NUM_PROC.

## Structure
- Package `test_area_prmter_deadlock_pkg` holds:
  - the FSM state enum (2-bit encoding),
  - the REPORT_W computation function,
  - TS_W = 32,
  - field offset constants for `report_data`.
- Sub-module `test_area_prmter_stall_counter` provides a saturating counter with clear, increment and a compare-to-threshold flag. It is used for stall_count; event_count uses a plain inline saturating counter.

## Test plan
- thr = 4, `block` high for 3 cycles then low → no `report_valid`, FSM back in ARMED, event_count 0.
- thr = 4, `block` held high, `report_ready` = 1 → `report_valid` pulses 1 cycle at cycle 4, stall_count field = 4, `deadlock_irq` = 1, event_count = 1.
- thr = 2, vectors idle = 5'b00101, chan = 5'b01010, axis = 5'b10000, `report_ready` = 0 for 5 cycles → `report_data` stable and equal to the snapshot throughout, vectors changed meanwhile.
- After a report with `block` still high, pulse `irq_clear` → `deadlock_irq` = 0, no new report; drop `block` for 1 cycle, raise again → second report, event_count = 2.
- thr = 0 → report after a single blocked cycle; `enable` = 0 with `block` high for 100 cycles → no report.
- Assert `reset` low while in REPORT → `report_valid` drops immediately (asynchronous); after release all outputs are 0 and a fresh detection works.
